fifo_halfwidth_drain_ctrl: RTL
==============================

// Module: fifo_halfwidth_drain_ctrl
// PURPOSE
//  Read-side sequencer for a half-width-read FIFO (first-word fall-through). Drains a commanded number
//  of half-words, delivering full words when two or more halves remain and single halves otherwise.
//  Drives read/onlyReadHalf and tracks the dangling-half state across commands.
//  Sits between the FIFO read port and a valid/ready consumer; one controller per FIFO.
// PARAMETERS
//  WIDTH      6   FIFO word width; must be even; HALF = WIDTH/2
//  MAX_HALVES 64  largest cmd_count accepted; CW = $clog2(MAX_HALVES+1)
// PORTS
//  clk               in   1      single clock, rising edge
//  reset             in   1      asynchronous, active-high
//  cmd_valid         in   1      command offered
//  cmd_count         in   CW     half-words to deliver; 0 is legal
//  cmd_ready         out  1      controller idle, command accepted when cmd_valid&cmd_ready
//  abort             in   1      terminate the current command
//  done              out  1      one-cycle pulse when the command finishes or aborts
//  fifo_valid        in   1      FIFO head valid
//  fifo_dataout      in   WIDTH  FIFO head
//  fifo_read         out  1      consume from FIFO
//  fifo_onlyReadHalf out  1      with fifo_read: consume low half only
//  out_data          out  WIDTH  beat data; a half beat uses [HALF-1:0], upper bits 0
//  out_half          out  1      beat carries one half-word
//  out_valid         out  1      beat offered
//  out_ready         in   1      consumer accepts
//  half_pending      out  1      FIFO head has its low half consumed
// BEHAVIOUR
//  - FIFO contract: read&onlyReadHalf on a fresh head consumes its low half. The head then stays and
//    presents its remaining half on fifo_dataout[HALF-1:0]. Any read on a half-consumed head pops it.
//  - Reset values: state=IDLE, cmd_ready=1, done=0, remaining=0, half_pending=0, out_valid=0, fifo_read=0.
//  - FSM IDLE -> RUN on cmd accept with cmd_count>0; IDLE -> FIN on cmd accept with cmd_count=0.
//    RUN -> FIN when the beat taking remaining to 0 transfers, or when abort=1. FIN -> IDLE always.
//    done=1 only in FIN.
//  - In RUN the beat type is chosen combinationally:
//    * half_pending=1 -> half beat; fifo_read=1, onlyReadHalf=0; clears half_pending.
//    * half_pending=0 and remaining>=2 -> full beat; fifo_read=1, onlyReadHalf=0.
//    * half_pending=0 and remaining=1 -> half beat of the low half; fifo_read=1, onlyReadHalf=1;
//      sets half_pending.
//  - out_valid = RUN & fifo_valid & !abort; zero-latency fall-through. out_data/out_half are combinational.
//  - fifo_read = out_valid & out_ready. No FIFO access outside RUN.
//  - remaining decrements by 2 (full beat) or 1 (half beat) on transfer. Unsigned; never underflows.
//  - A stall (out_ready=0) or FIFO empty holds all state; out_data follows the FIFO head.
//  - half_pending persists across commands and aborts. The next command starts with the dangling half.
//  - abort in RUN: the beat offered that cycle is withdrawn (no read). FIN follows and remaining clears.
//    abort outside RUN is ignored.
//  - A cmd_count above MAX_HALVES is saturated to MAX_HALVES.
//  - reset mid-command returns to reset values at once. The FIFO shares this reset, so half_pending
//    stays coherent.
// STRUCTURE
//  - fifoPkg gains: typedef enum logic [1:0] {DRAIN_IDLE, DRAIN_RUN, DRAIN_FIN} drainState_t,
//    and function halfWidth(WIDTH) returning WIDTH/2.
//  - One natural sub-module: fifo_half_beat_select. It is combinational and takes half_pending,
//    remaining and fifo_dataout. It returns beat type, onlyReadHalf, decrement and out_data.
//    The FSM and counters stay in the top.
// TESTING  (WIDTH=6, HALF=3; FIFO preloaded with 6'b101001, 6'b110010, 6'b111011)
//  1 cmd_count=4, out_ready=1 -> full beats 101001 then 110010, onlyReadHalf=0 both, done pulses, cmd_ready returns.
//  2 cmd_count=3 -> full 101001, then half 3'b010 with onlyReadHalf=1, half_pending=1.
//    Then cmd_count=1 -> half 3'b110, onlyReadHalf=0, half_pending=0.
//  3 cmd_count=2 with out_ready=0 for 3 cycles -> out_valid held, no fifo_read, data stable; transfers on cycle 4.
//  4 Empty FIFO, cmd_count=2 -> out_valid=0 until write of 6'b111011; it falls through as a full beat the same cycle.
//  5 cmd_count=6, abort after first beat -> no read that cycle, done next cycle, remaining=0, FIFO keeps 2 words.
//  6 cmd_count=0 -> done one cycle after accept, no fifo_read.
//    reset asserted mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fifo_halfwidth_drain_ctrl_pkg.sv
// Shared types and helpers for the half-width FIFO drain controller.
package fifo_halfwidth_drain_ctrl_pkg;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_RUN  = 2'd1,
    DRAIN_FIN  = 2'd2
  } drainState_t;

  function automatic int halfWidth(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/fifo_halfwidth_drain_ctrl_if.sv
// Command, FIFO read-port and output-stream signals of the drain controller.
// The controller side uses the slave modport; the surrounding environment uses master.
interface fifo_halfwidth_drain_ctrl_if #(
  parameter int WIDTH = 6,
  parameter int CW    = 7
);
  logic             cmd_valid;
  logic [CW-1:0]    cmd_count;
  logic             cmd_ready;
  logic             abort;
  logic             done;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_dataout;
  logic             fifo_read;
  logic             fifo_onlyReadHalf;
  logic [WIDTH-1:0] out_data;
  logic             out_half;
  logic             out_valid;
  logic             out_ready;
  logic             half_pending;

  modport slave (
    input  cmd_valid, cmd_count, abort, fifo_valid, fifo_dataout, out_ready,
    output cmd_ready, done, fifo_read, fifo_onlyReadHalf, out_data, out_half,
           out_valid, half_pending
  );

  modport master (
    output cmd_valid, cmd_count, abort, fifo_valid, fifo_dataout, out_ready,
    input  cmd_ready, done, fifo_read, fifo_onlyReadHalf, out_data, out_half,
           out_valid, half_pending
  );
endinterface

// File: rtl/fifo_half_beat_select.sv
// Chooses the shape of the next beat from the dangling-half flag and the
// number of half-words still owed by the current command.
module fifo_half_beat_select
  import fifo_halfwidth_drain_ctrl_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CW    = 7
) (
  input  logic             half_pending,
  input  logic [CW-1:0]    remaining,
  input  logic [WIDTH-1:0] fifo_dataout,
  output logic             beat_half,
  output logic             only_half,
  output logic [1:0]       dec,
  output logic [WIDTH-1:0] beat_data
);
  localparam int HALF = halfWidth(WIDTH);

  // A dangling high half, or a lone last half-word, goes out as a half beat
  // on the low lane; otherwise the whole head word goes out.
  always_comb begin
    beat_half = 1'b1;
    only_half = 1'b0;
    dec       = 2'd1;
    beat_data = {{HALF{1'b0}}, fifo_dataout[HALF-1:0]};
    if (!half_pending) begin
      if (remaining >= CW'(2)) begin
        beat_half = 1'b0;
        dec       = 2'd2;
        beat_data = fifo_dataout;
      end else begin
        only_half = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_halfwidth_drain_ctrl.sv
// Read-side sequencer for a half-width-read, first-word fall-through FIFO.
// Drains a commanded number of half-words and tracks whether the FIFO head
// has already lost its low half, across commands and aborts.
module fifo_halfwidth_drain_ctrl
  import fifo_halfwidth_drain_ctrl_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int MAX_HALVES = 64
) (
  input logic                        clk,
  input logic                        reset,
  fifo_halfwidth_drain_ctrl_if.slave bus
);
  localparam int             CW      = $clog2(MAX_HALVES + 1);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_HALVES);

  drainState_t      state_q, state_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic             half_pending_q, half_pending_d;

  logic             beat_half;
  logic             only_half;
  logic [1:0]       dec;
  logic [WIDTH-1:0] beat_data;
  logic             xfer;

  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] cnt);
    return (cnt > MAX_CNT) ? MAX_CNT : cnt;
  endfunction

  fifo_half_beat_select #(.WIDTH(WIDTH), .CW(CW)) u_sel (
    .half_pending (half_pending_q),
    .remaining    (remaining_q),
    .fifo_dataout (bus.fifo_dataout),
    .beat_half    (beat_half),
    .only_half    (only_half),
    .dec          (dec),
    .beat_data    (beat_data)
  );

  // Abort withdraws the beat in the same cycle, so it gates out_valid directly.
  assign bus.out_valid         = (state_q == DRAIN_RUN) & bus.fifo_valid & ~bus.abort;
  assign xfer                  = bus.out_valid & bus.out_ready;
  assign bus.fifo_read         = xfer;
  assign bus.fifo_onlyReadHalf = xfer & only_half;
  assign bus.out_data          = beat_data;
  assign bus.out_half          = beat_half;
  assign bus.cmd_ready         = (state_q == DRAIN_IDLE);
  assign bus.done              = (state_q == DRAIN_FIN);
  assign bus.half_pending      = half_pending_q;

  // Next-state, remaining-count and dangling-half bookkeeping.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    half_pending_d = half_pending_q;
    unique case (state_q)
      DRAIN_IDLE: begin
        if (bus.cmd_valid) begin
          remaining_d = sat_count(bus.cmd_count);
          state_d     = (sat_count(bus.cmd_count) == '0) ? DRAIN_FIN : DRAIN_RUN;
        end
      end
      DRAIN_RUN: begin
        if (bus.abort) begin
          remaining_d = '0;
          state_d     = DRAIN_FIN;
        end else if (xfer) begin
          remaining_d    = remaining_q - CW'(dec);
          half_pending_d = half_pending_q ? 1'b0 : only_half;
          if (remaining_q == CW'(dec)) state_d = DRAIN_FIN;
        end
      end
      DRAIN_FIN: begin
        state_d = DRAIN_IDLE;
      end
      default: begin
        state_d     = DRAIN_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // State register; reset is shared with the FIFO so half_pending stays coherent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= DRAIN_IDLE;
      remaining_q    <= '0;
      half_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      half_pending_q <= half_pending_d;
    end
  end
endmodule
